// File: rtl/fifo_pkg.sv
// Shared helpers for the FIFO family: size derivation and reset values.
// Pointers carry one extra wrap bit beyond the address so full and empty stay distinguishable.
package fifo_pkg;

    function automatic int clog2(input int value);
        int result;
        result = 32'sd0;
        while ((32'sd1 << result) < value) begin
            result = result + 32'sd1;
        end
        return result;
    endfunction

    function automatic int ptr_width(input int depth);
        return clog2(depth) + 32'sd1;
    endfunction

    localparam logic RST_EMPTY        = 1'b1;
    localparam logic RST_FULL         = 1'b0;
    localparam logic RST_ALMOST_EMPTY = 1'b1;
    localparam logic RST_ALMOST_FULL  = 1'b0;
    localparam logic RST_FLAG         = 1'b0;

endpackage

// File: rtl/fifo_ram.sv
// DEPTH x WIDTH storage: synchronous write port, asynchronous read by address.
module fifo_ram
    import fifo_pkg::*;
#(
    parameter int WIDTH = 32'sd8,
    parameter int DEPTH = 32'sd16
) (
    input  logic                      clk,
    input  logic                      we,
    input  logic [clog2(DEPTH)-1:0]   waddr,
    input  logic [WIDTH-1:0]          wdata,
    input  logic [clog2(DEPTH)-1:0]   raddr,
    output logic [WIDTH-1:0]          rdata
);

    logic [WIDTH-1:0] mem_r [DEPTH];

    // Store the accepted write word; contents are never reset
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    assign rdata = mem_r[raddr];

endmodule

// File: rtl/fifo_param.sv
// Parametrised single-clock FIFO with thresholds, occupancy, sticky errors,
// synchronous flush and optional show-ahead output.
module fifo_param
    import fifo_pkg::*;
#(
    parameter int WIDTH      = 32'sd8,
    parameter int DEPTH      = 32'sd16,
    parameter int AF_LEVEL   = DEPTH - 32'sd2,
    parameter int AE_LEVEL   = 32'sd2,
    parameter int SHOW_AHEAD = 32'sd0
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          clear,
    input  logic                          w,
    input  logic [WIDTH-1:0]              data_in,
    input  logic                          r,
    output logic [WIDTH-1:0]              out,
    output logic                          full,
    output logic                          empty,
    output logic                          almost_full,
    output logic                          almost_empty,
    output logic [ptr_width(DEPTH)-1:0]   count,
    output logic                          overflow,
    output logic                          underflow
);

    localparam int AW = clog2(DEPTH);
    localparam int PW = ptr_width(DEPTH);

    logic [PW-1:0]    wr_ptr_r, rd_ptr_r, count_r;
    logic             full_r, empty_r, afull_r, aempty_r, ovf_r, udf_r;
    logic [WIDTH-1:0] out_r;

    logic             rd_ok_s, wr_ok_s, ram_we_s, ovf_n_s, udf_n_s;
    logic [PW-1:0]    wr_ptr_n_s, rd_ptr_n_s, count_n_s;
    logic             full_n_s, empty_n_s;
    logic [AW-1:0]    ram_raddr_s;
    logic [WIDTH-1:0] ram_rdata_s, out_n_s;

    fifo_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we_s),
        .waddr (wr_ptr_r[AW-1:0]),
        .wdata (data_in),
        .raddr (ram_raddr_s),
        .rdata (ram_rdata_s)
    );

    // Accept/reject requests and derive next pointers, occupancy and sticky flags
    always_comb begin
        rd_ok_s = r & ~empty_r;
        wr_ok_s = w & (~full_r | rd_ok_s);
        if (clear) begin
            wr_ptr_n_s = '0;
            rd_ptr_n_s = '0;
            ovf_n_s    = RST_FLAG;
            udf_n_s    = RST_FLAG;
            ram_we_s   = 1'b0;
        end else begin
            wr_ptr_n_s = wr_ok_s ? wr_ptr_r + PW'(1'b1) : wr_ptr_r;
            rd_ptr_n_s = rd_ok_s ? rd_ptr_r + PW'(1'b1) : rd_ptr_r;
            ovf_n_s    = ovf_r | (w & ~wr_ok_s);
            udf_n_s    = udf_r | (r & ~rd_ok_s);
            ram_we_s   = wr_ok_s;
        end
        count_n_s = wr_ptr_n_s - rd_ptr_n_s;
        empty_n_s = (wr_ptr_n_s == rd_ptr_n_s);
        full_n_s  = (wr_ptr_n_s[AW] != rd_ptr_n_s[AW]) &&
                    (wr_ptr_n_s[AW-1:0] == rd_ptr_n_s[AW-1:0]);
    end

    // Next output word; show-ahead forwards a word written straight into the head slot
    always_comb begin
        ram_raddr_s = (SHOW_AHEAD != 32'sd0) ? rd_ptr_n_s[AW-1:0] : rd_ptr_r[AW-1:0];
        if (clear) begin
            out_n_s = '0;
        end else if (SHOW_AHEAD != 32'sd0) begin
            if (wr_ok_s && (rd_ptr_n_s == wr_ptr_r)) begin
                out_n_s = data_in;
            end else begin
                out_n_s = ram_rdata_s;
            end
        end else if (rd_ok_s) begin
            out_n_s = ram_rdata_s;
        end else begin
            out_n_s = out_r;
        end
    end

    // Register pointers, occupancy, status and read data
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
            full_r   <= RST_FULL;
            empty_r  <= RST_EMPTY;
            afull_r  <= RST_ALMOST_FULL;
            aempty_r <= RST_ALMOST_EMPTY;
            ovf_r    <= RST_FLAG;
            udf_r    <= RST_FLAG;
            out_r    <= '0;
        end else begin
            wr_ptr_r <= wr_ptr_n_s;
            rd_ptr_r <= rd_ptr_n_s;
            count_r  <= count_n_s;
            full_r   <= full_n_s;
            empty_r  <= empty_n_s;
            afull_r  <= (count_n_s >= PW'(AF_LEVEL));
            aempty_r <= (count_n_s <= PW'(AE_LEVEL));
            ovf_r    <= ovf_n_s;
            udf_r    <= udf_n_s;
            out_r    <= out_n_s;
        end
    end

    assign out          = out_r;
    assign full         = full_r;
    assign empty        = empty_r;
    assign almost_full  = afull_r;
    assign almost_empty = aempty_r;
    assign count        = count_r;
    assign overflow     = ovf_r;
    assign underflow    = udf_r;

endmodule

// File: doc/fifo_param.md
# fifo_param

Parametrised synchronous FIFO replacing the fixed 16×8 `fifo` buffer in the datapath. It adds configurable width and depth, programmable almost-full/almost-empty thresholds, an occupancy count, sticky overflow/underflow error flags, a synchronous flush and a selectable show-ahead read mode. It sits between a producer and a consumer in one clock domain and is the standard buffer for new blocks.

## Interface

- `WIDTH`, 8: data word width in bits, ≥1.
- `DEPTH`, 16: number of entries; power of two, ≥4.
- `AF_LEVEL`, DEPTH-2: `almost_full` asserts when count ≥ AF_LEVEL.
- `AE_LEVEL`, 2: `almost_empty` asserts when count ≤ AE_LEVEL.
- `SHOW_AHEAD`, 0: 0 = registered read, 1 = head word visible on `out` without a read.

- `clk` in 1: single clock; all logic on the rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `clear` in 1: synchronous flush; empties FIFO, clears error flags.
- `w` in 1: write request.
- `data_in` in WIDTH: write data, sampled on the rising edge with `w`.
- `r` in 1: read request.
- `out` out WIDTH: read data.
- `full` out 1: count == DEPTH.
- `empty` out 1: count == 0.
- `almost_full` out 1: count ≥ AF_LEVEL.
- `almost_empty` out 1: count ≤ AE_LEVEL.
- `count` out log2(DEPTH)+1: current occupancy, 0..DEPTH.
- `overflow` out 1: sticky; a write was rejected.
- `underflow` out 1: sticky; a read was rejected.

## Operation

- Reset values while `reset`=0: `out`=0, `count`=0, `empty`=1, `full`=0, `almost_empty`=1, `almost_full`=0, `overflow`=0, `underflow`=0; pointers 0. Reset mid-operation discards all contents; memory contents need not be cleared.
- Pointers are log2(DEPTH)+1 bits; address = low bits; full/empty from MSB comparison. Wrap-around from DEPTH-1 to 0 is silent.
- Write accepted when `w`=1 and (`full`=0 or `r`=1 with the read accepted). Write while full without accepted read: dropped, `overflow`←1.
- Read accepted when `r`=1 and `empty`=0. Read while empty: ignored, `underflow`←1, `out` holds. A simultaneous write into an empty FIFO is accepted; the read is not.
- `r`&`w` both accepted: `count` unchanged, pointers both advance.
- `clear`=1 has priority over `r`/`w`: pointers and count ← 0, flags ← 0, `out` ← 0; the same-cycle write is discarded.
- Status outputs are registered, derived from next-state count; no combinational path from `r`/`w` to any status output.

## Timing

- Write latency: word written on edge N; `empty` falls and `count` increments after edge N.
- SHOW_AHEAD=0: `out` loads the head word on the edge that accepts the read (one cycle), then holds until the next accepted read.
- SHOW_AHEAD=1: `out` shows the head word one cycle after it is written into an empty FIFO; an accepted read advances `out` to the next word after the same edge. `out` is don't-care while `empty`=1.
- `full` asserts after the edge accepting the DEPTH-th write; deasserts after the edge accepting a read.
- Error flags assert the cycle after the offending request and stay set until `clear` or `reset`.

## Structure

- Shared package `fifo_pkg`: `clog2` function, pointer/count width derivation, reset-value constants; reused by other FIFO variants.
- Sub-module `fifo_ram`: DEPTH×WIDTH dual-port array, synchronous write, asynchronous read by address; the top holds pointers, count, flags and output register.

## Test plan

- Reset then idle: `empty`=1, `almost_empty`=1, `count`=0, `out`=0, flags 0; assert `reset`=0 mid-fill of 5 words -> `count`=0, `empty`=1 immediately.
- Write 0x01..0x10 (DEPTH=16): `almost_full` at count 14, `full` after 16th write; 17th write -> dropped, `overflow`=1, `count`=16.
- Read all 16 (SHOW_AHEAD=0): `out` = 0x01..0x10 in order one cycle after each read; extra read -> `underflow`=1, `out` holds 0x10.
- Simultaneous `r`&`w` at full and at count 7 -> count unchanged, order preserved across pointer wrap; at empty -> write accepted, `underflow`=1, `count`=1.
- `clear` with `w`=1 at count 9 -> `count`=0, `empty`=1, flags cleared, written word absent.
- SHOW_AHEAD=1, WIDTH=12, DEPTH=8: write 0xABC into empty -> `out`=0xABC next cycle with no read; write 0x123 then read -> `out`=0x123 after the read edge.
